// File: rtl/cyber_pkg.sv
// Shared types and constants for the automated "cyber" player that presses
// the playfield R input at pseudo-random intervals.
package cyber_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } player_state_t;

    // XNOR feedback; the all-ones state would repeat forever, so it is
    // steered back to zero, the state the sequence starts from.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        if (q == LFSR_LOCKUP) begin
            return '0;
        end
        return {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR that steps once per asserted advance; holds otherwise.
module lfsr10
    import cyber_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (advance) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/cyber_player.sv
// Automated player: prescaled decision ticks compare the difficulty switch
// bank against an LFSR and issue single-cycle presses with a tick holdoff.
module cyber_player
    import cyber_pkg::*;
#(
    parameter int TICK_DIV = 8,
    parameter int HOLDOFF  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        difficulty,
    input  logic              game_over,
    output logic              press,
    output logic [LFSR_W-1:0] lfsr_q
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               advance;

    player_state_t state_q, state_d;
    logic [3:0]    hold_cnt_q, hold_cnt_d;
    logic          press_wins;

    assign tick    = (presc_q == PRESC_LAST);
    assign advance = tick & ~game_over;

    // NOTE: reset is synchronous and clears every flop here; there is no
    // storage array, so nothing is left to rely on power-up values.
    always_ff @(posedge clk) begin
        if (reset || game_over || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    lfsr10 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .q       (lfsr_q)
    );

    // Compare uses the pre-advance LFSR value seen during the tick cycle.
    assign press_wins = ({1'b0, difficulty} > lfsr_q);

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (advance && press_wins) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                state_d    = HOLD;
                hold_cnt_d = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else if (advance) begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                    if (hold_cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A frozen game abandons any pending press and keeps the holdoff count.
        if (game_over) begin
            state_d    = IDLE;
            hold_cnt_d = hold_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign press = (state_q == PRESS) & ~game_over;

endmodule
